// File: rtl/booth_divider_pkg.sv
// Shared definitions for the Booth divider: FSM state encodings and default width.
package booth_divider_pkg;

    // Default operand width; the dividend is twice this wide.
    localparam int DEFAULT_WIDTH = 32;

    // Controller states, walked in order IDLE -> PREP -> ITER... -> FIX -> DONE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Width of an iteration counter that must hold the value w-1.
    function automatic int cntBits(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/booth_divider_step.sv
// One radix-2 non-restoring division step: shift in the next dividend bit,
// then subtract the divisor magnitude if the partial remainder is
// non-negative, otherwise add it back. The quotient bit is 1 when the new
// remainder is non-negative.
module booth_divider_step #(
    parameter int W = 32
) (
    input  logic [W+1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W+1:0] rem_o,
    output logic         qbit_o
);

    logic [W+1:0] shifted;
    logic [W+1:0] divExt;

    // Remainder stays within (-|divisor|, |divisor|), so the sign bit of the
    // shifted value is carried correctly by the lower W+1 bits.
    always_comb begin
        shifted = {rem_i[W:0], bit_i};
        divExt  = {2'b00, divisor_i};
        rem_o   = rem_i[W+1] ? (shifted + divExt) : (shifted - divExt);
        qbit_o  = ~rem_o[W+1];
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock using non-restoring iteration on operand magnitudes, with
// signs applied at the end. Flags divide-by-zero and quotient overflow.
module booth_divider
    import booth_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int W     = WIDTH;
    localparam int CNT_W = cntBits(W);
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*W-1:0]     dividend_q;
    logic [W-1:0]       divisor_q;
    logic [W-1:0]       divisorMag_q;
    logic [W+1:0]       partRem_q;
    logic [W-1:0]       quoBits_q;
    logic               qNeg_q;
    logic               rNeg_q;
    logic [W-1:0]       quotient_q;
    logic [W-1:0]       remainder_q;
    logic               dbz_q;
    logic               ovf_q;
    logic               done_q;

    logic [2*W-1:0]     dividendMag_d;
    logic [W-1:0]       divisorMag_d;
    logic [W+1:0]       partRem_d;
    logic               quoBit_d;
    logic [W-1:0]       remMag_d;
    logic [W-1:0]       quoFinal_d;
    logic [W-1:0]       remFinal_d;
    logic               ovfFix_d;

    // Single iteration of the non-restoring recurrence. The next dividend bit
    // comes from the top of the quotient shift register, which starts out
    // holding the low half of |dividend|.
    booth_divider_step #(
        .W (W)
    ) u_step (
        .rem_i     (partRem_q),
        .bit_i     (quoBits_q[W-1]),
        .divisor_i (divisorMag_q),
        .rem_o     (partRem_d),
        .qbit_o    (quoBit_d)
    );

    // Operand magnitudes (the most-negative values map to their unsigned
    // magnitude) and the sign fix-up applied after the last iteration.
    always_comb begin
        dividendMag_d = dividend_q[2*W-1] ? -dividend_q : dividend_q;
        divisorMag_d  = divisor_q[W-1]    ? -divisor_q  : divisor_q;
        remMag_d      = partRem_q[W+1] ? (partRem_q[W-1:0] + divisorMag_q)
                                       : partRem_q[W-1:0];
        ovfFix_d      = qNeg_q ? (quoBits_q > HALF) : quoBits_q[W-1];
        quoFinal_d    = qNeg_q ? -quoBits_q : quoBits_q;
        remFinal_d    = rNeg_q ? -remMag_d  : remMag_d;
    end

    // Controller, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            divisorMag_q <= '0;
            partRem_q    <= '0;
            quoBits_q    <= '0;
            qNeg_q       <= 1'b0;
            rNeg_q       <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            dbz_q        <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        dbz_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    quotient_q   <= '0;
                    remainder_q  <= '0;
                    divisorMag_q <= divisorMag_d;
                    qNeg_q       <= dividend_q[2*W-1] ^ divisor_q[W-1];
                    rNeg_q       <= dividend_q[2*W-1];
                    partRem_q    <= {2'b00, dividendMag_d[2*W-1:W]};
                    quoBits_q    <= dividendMag_d[W-1:0];
                    cnt_q        <= CNT_W'(W - 1);
                    if (divisor_q == '0) begin
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (dividendMag_d[2*W-1:W] >= divisorMag_d) begin
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    partRem_q <= partRem_d;
                    quoBits_q <= {quoBits_q[W-2:0], quoBit_d};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (ovfFix_d) begin
                        ovf_q <= 1'b1;
                    end else begin
                        quotient_q  <= quoFinal_d;
                        remainder_q <= remFinal_d;
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed scenarios plus randomized
// operands compared against a wide-integer reference model.
module tb_booth_divider;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [63:0]   dividend;
    logic [31:0]   divisor;
    logic          busy;
    logic          done;
    logic [31:0]   quotient;
    logic [31:0]   remainder;
    logic          div_by_zero;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    booth_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed division on 128-bit integers, truncating
    // toward zero; results outside signed 32 bits are overflow. Quotients
    // with magnitude of 2^32 or more are caught before iterating.
    task automatic model(input logic [63:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output logic ovf, output int lat);
        logic signed [127:0] aa;
        logic signed [127:0] bb;
        logic signed [127:0] qq;
        logic signed [127:0] rr;
        aa  = {{64{a[63]}}, a};
        bb  = {{96{b[31]}}, b};
        q   = '0;
        r   = '0;
        dbz = 1'b0;
        ovf = 1'b0;
        lat = 35;
        if (b == 32'd0) begin
            dbz = 1'b1;
            lat = 2;
        end else begin
            qq = aa / bb;
            rr = aa % bb;
            if (qq >= 128'sh1_0000_0000 || qq <= -128'sh1_0000_0000) begin
                ovf = 1'b1;
                lat = 2;
            end else if (qq > 128'sh7FFF_FFFF || qq < -128'sh8000_0000) begin
                ovf = 1'b1;
            end else begin
                q = qq[31:0];
                r = rr[31:0];
            end
        end
    endtask

    // Wait at a falling edge until the divider is idle (bounded).
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one operation and wait for done; lat counts rising edges from
    // the edge that accepts start up to the one after which done is seen.
    task automatic applyStimulus(input logic [63:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] q,
                                 output logic [31:0] r, output logic dbz,
                                 output logic ovf);
        waitIdle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        ovf = overflow;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state got busy=%0b done=%0b q=%h r=%h dbz=%0b ovf=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_with_rst got busy=%0b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] q, r;
        logic dbz, ovf;
        applyStimulus(64'd100, 32'd7, lat, q, r, dbz, ovf);
        total++;
        if ({q, r, dbz, ovf} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL basic_100_7 got q=%0d r=%0d dbz=%0b ovf=%0b want q=14 r=2 dbz=0 ovf=0",
                     $signed(q), $signed(r), dbz, ovf);
        end
        total++;
        if (lat !== 35) begin
            bad++;
            $display("[TB] FAIL basic_latency got %0d want 35", lat);
        end
        @(posedge clk);
        #1;
        total++;
        if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 32'd14, 32'd2}) begin
            bad++;
            $display("[TB] FAIL basic_hold got done=%0b busy=%0b q=%0d r=%0d want done=0 busy=0 q=14 r=2",
                     done, busy, $signed(quotient), $signed(remainder));
        end
    endtask

    task automatic test_signs();
        logic [63:0] a;
        logic [31:0] b, eq, er, q, r;
        logic dbz, ovf;
        int lat;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin a = -64'sd100; b = 32'd7;   eq = -32'sd14; er = -32'sd2; end
                1: begin a = 64'd100;   b = -32'sd7; eq = -32'sd14; er = 32'd2;   end
                default: begin a = -64'sd100; b = -32'sd7; eq = 32'd14; er = -32'sd2; end
            endcase
            applyStimulus(a, b, lat, q, r, dbz, ovf);
            total++;
            if ({q, r, dbz, ovf, lat} !== {eq, er, 1'b0, 1'b0, 35}) begin
                bad++;
                $display("[TB] FAIL signs_%0d got q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d want q=%0d r=%0d flags 0 lat=35",
                         i, $signed(q), $signed(r), dbz, ovf, lat, $signed(eq), $signed(er));
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] q, r;
        logic dbz, ovf;
        applyStimulus(64'd5, 32'd0, lat, q, r, dbz, ovf);
        total++;
        if ({q, r, dbz, ovf, lat} !== {32'd0, 32'd0, 1'b1, 1'b0, 2}) begin
            bad++;
            $display("[TB] FAIL div_zero got q=%h r=%h dbz=%0b ovf=%0b lat=%0d want q=0 r=0 dbz=1 ovf=0 lat=2",
                     q, r, dbz, ovf, lat);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] a;
        logic [31:0] b, eq, q, r;
        logic eovf, dbz, ovf;
        int elat, lat;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin a = 64'h100_0000_0000;        b = 32'd1; eq = 32'd0;         eovf = 1'b1; elat = 2;  end
                1: begin a = 64'h8000_0000;            b = 32'd1; eq = 32'd0;         eovf = 1'b1; elat = 35; end
                2: begin a = 64'hFFFF_FFFF_8000_0000;  b = 32'd1; eq = 32'h8000_0000; eovf = 1'b0; elat = 35; end
                3: begin a = 64'h8000_0000_0000_0000;  b = 32'hFFFF_FFFF; eq = 32'd0; eovf = 1'b1; elat = 2;  end
                default: begin a = 64'h4000_0000_0000_0000; b = 32'h8000_0000; eq = 32'h8000_0000; eovf = 1'b0; elat = 35; end
            endcase
            applyStimulus(a, b, lat, q, r, dbz, ovf);
            total++;
            if ({q, r, dbz, ovf, lat} !== {eq, 32'd0, 1'b0, eovf, elat}) begin
                bad++;
                $display("[TB] FAIL overflow_%0d got q=%h r=%h dbz=%0b ovf=%0b lat=%0d want q=%h r=0 dbz=0 ovf=%0b lat=%0d",
                         i, q, r, dbz, ovf, lat, eq, eovf, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, extra;
        waitIdle();
        dividend = 64'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 80) begin
            if (lat == 6) begin
                @(negedge clk);
                dividend = 64'd77;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        total++;
        if (lat !== 35) begin
            bad++;
            $display("[TB] FAIL busy_ignore_latency got %0d want 35", lat);
        end
        @(negedge clk);
        dividend = 64'd99;
        divisor  = 32'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_in_done got busy=%0b want 0", busy);
        end
        extra = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL extra_done got %0d pulses want 0", extra);
        end
        total++;
        if ({quotient, remainder, div_by_zero, overflow} !== {32'd333, 32'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL busy_ignore_result got q=%0d r=%0d dbz=%0b ovf=%0b want q=333 r=1 flags 0",
                     $signed(quotient), $signed(remainder), div_by_zero, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        logic [31:0] q, r;
        logic dbz, ovf;
        waitIdle();
        dividend = 64'd5000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (lat < 11) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset got busy=%0b done=%0b q=%h r=%h dbz=%0b ovf=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL mid_reset_done got %0d pulses want 0", pulses);
        end
        applyStimulus(64'd42, 32'd6, lat, q, r, dbz, ovf);
        total++;
        if ({q, r, dbz, ovf, lat} !== {32'd7, 32'd0, 1'b0, 1'b0, 35}) begin
            bad++;
            $display("[TB] FAIL after_reset_42_6 got q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d want q=7 r=0 flags 0 lat=35",
                     $signed(q), $signed(r), dbz, ovf, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] b, q, r, eq, er;
        logic dbz, ovf, edbz, eovf;
        int lat, elat, ti, kind;
        longint qv, dv, rv, tmp;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    a = {$urandom, $urandom};
                    b = $urandom;
                end
                1: begin
                    qv = longint'(int'($urandom));
                    dv = longint'(int'($urandom)) >>> $urandom_range(0, 30);
                    if (dv == 0) dv = 3;
                    rv = longint'($urandom_range(0, 32'h7FFF_FFFF)) % ((dv < 0) ? -dv : dv);
                    tmp = qv * dv + (($urandom_range(0, 1) == 1) ? rv : -rv);
                    a = tmp;
                    b = dv[31:0];
                end
                2: begin
                    tmp = longint'($urandom_range(0, 2000)) - 1000;
                    ti  = int'($urandom_range(0, 40)) - 20;
                    a = tmp;
                    b = ti;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 64'h8000_0000_0000_0000;
                        1: a = 64'hFFFF_FFFF_8000_0000;
                        2: a = 64'h0000_0000_7FFF_FFFF;
                        default: a = 64'h3FFF_FFFF_C000_0000;
                    endcase
                    case ($urandom_range(0, 3))
                        0: b = 32'h8000_0000;
                        1: b = 32'd1;
                        2: b = 32'hFFFF_FFFF;
                        default: b = 32'h7FFF_FFFF;
                    endcase
                end
            endcase
            model(a, b, eq, er, edbz, eovf, elat);
            applyStimulus(a, b, lat, q, r, dbz, ovf);
            total++;
            if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
                bad++;
                $display("[TB] FAIL random_%0d a=%h b=%h got q=%h r=%h dbz=%0b ovf=%0b want q=%h r=%h dbz=%0b ovf=%0b",
                         i, a, b, q, r, dbz, ovf, eq, er, edbz, eovf);
            end
            total++;
            if (lat !== elat) begin
                bad++;
                $display("[TB] FAIL random_latency_%0d a=%h b=%h got %0d want %0d", i, a, b, lat, elat);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit in case the sequence above ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
